uart_rx: RTL and testbench

- UART receiver, the counterpart of uart_tx, using the same frame-format and clock-divider controls.
- Deserialises an asynchronous 8N1/8N2/8E1/8O1 (and 2-stop parity) line into bytes.
- Flags parity and framing errors.
- Sits between the pad-side serial input and the byte-consuming logic; uart_tx serial_o loops directly into serial_i for self-test.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame width and
// the parity helper used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned DIV_W          = 16;
  localparam int unsigned PAR_W          = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_e;

  // Parity bit a transmitter appends; callers zero-extend, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [PAR_W-1:0] data, input logic even);
    return even ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing; o_expire_c fires when the count
// reaches zero and the counter then reloads itself with i_reload_val.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic [DIV_W-1:0] i_reload_val,
  output logic             o_expire_c
);

  logic [DIV_W-1:0] r_count;

  assign o_expire_c = i_run && !i_load && (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (o_expire_c) begin
      r_count <= i_reload_val;
    end else if (i_run) begin
      r_count <= r_count - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises serial_i, times each bit from the start edge and
// delivers bytes with parity/framing flags. Optional: UART_RX_MAJORITY_VOTE_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 two_stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_even_i,
  input  logic [DIV_W-1:0]     clock_divider_i,
  input  logic                 serial_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 busy_o
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev_hi;
  logic                   w_rx_s;
  logic                   w_edge;

  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   r_perr_pend;
  logic                   w_perr_nxt;
  logic                   r_ferr_pend;
  logic                   w_ferr_nxt;
  logic                   w_done;
  logic                   w_arm;
  logic [DIV_W-1:0]       w_load_val;

  logic [DIV_W-1:0]       r_div;
  logic                   r_two_stop;
  logic                   r_par_en;
  logic                   r_par_even;
  logic [DIV_W-1:0]       w_div_in;
  logic [DIV_W-1:0]       w_half;

  logic                   w_expire;
  logic                   w_tick;
  logic                   w_sample;

  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_busy;

  // Reset values of the synchroniser are not line samples; r_fill marks when rx_s is real.
  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_edge = r_prev_hi && !w_rx_s;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync    <= '1;
      r_fill    <= '0;
      r_prev_hi <= 1'b0;
    end else begin
      r_sync    <= SYNC_STAGES'({r_sync, serial_i});
      r_fill    <= SYNC_STAGES'({r_fill, 1'b1});
      r_prev_hi <= r_fill[SYNC_STAGES-1] && w_rx_s;
    end
  end

  assign w_div_in = (clock_divider_i == '0) ? DIV_W'(1) : clock_divider_i;
  assign w_half   = w_div_in >> 1;

  uart_bit_timer u_timer (
    .i_clk        (clock_i),
    .i_rst_n      (reset_i),
    .i_run        (r_state != RX_IDLE),
    .i_load       (w_arm),
    .i_load_val   (w_load_val),
    .i_reload_val (r_div - DIV_W'(1)),
    .o_expire_c   (w_expire)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote needs the sample one clock past nominal, so the decision lands a cycle late.
  logic r_rx_d1;
  logic r_rx_d2;
  logic r_exp_d;
  logic w_vote_en;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
      r_exp_d <= 1'b0;
    end else begin
      r_rx_d1 <= w_rx_s;
      r_rx_d2 <= r_rx_d1;
      r_exp_d <= w_expire;
    end
  end

  assign w_vote_en = (r_div >= DIV_W'(4));
  assign w_tick    = w_vote_en ? r_exp_d : w_expire;
  assign w_sample  = w_vote_en ? ((w_rx_s & r_rx_d1) | (w_rx_s & r_rx_d2) | (r_rx_d1 & r_rx_d2))
                               : w_rx_s;
`else
  assign w_tick   = w_expire;
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= RX_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_perr_pend <= w_perr_nxt;
      r_ferr_pend <= w_ferr_nxt;
    end
  end

  // With a divider of 1 the detecting sample is the start-bit sample itself.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_bit_idx;
    w_perr_nxt  = r_perr_pend;
    w_ferr_nxt  = r_ferr_pend;
    w_done      = 1'b0;
    w_arm       = 1'b0;
    w_load_val  = '0;
    case (r_state)
      RX_IDLE: begin
        if (w_edge) begin
          w_arm       = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
          if (w_half == '0) begin
            w_state_nxt = RX_DATA;
            w_load_val  = w_div_in - DIV_W'(1);
          end else begin
            w_state_nxt = RX_START;
            w_load_val  = w_half - DIV_W'(1);
          end
        end
      end
      RX_START: begin
        if (w_tick) begin
          w_state_nxt = w_sample ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_shift_nxt[r_bit_idx] = w_sample;
          w_idx_nxt              = r_bit_idx + IDX_W'(1);
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_nxt = r_par_en ? RX_PARITY : RX_STOP1;
          end
        end
      end
      RX_PARITY: begin
        if (w_tick) begin
          w_perr_nxt  = (w_sample != parity_bit(PAR_W'(r_shift), r_par_even));
          w_state_nxt = RX_STOP1;
        end
      end
      RX_STOP1: begin
        if (w_tick) begin
          w_ferr_nxt = r_ferr_pend | !w_sample;
          if (r_two_stop) begin
            w_state_nxt = RX_STOP2;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = RX_IDLE;
          end
        end
      end
      RX_STOP2: begin
        if (w_tick) begin
          w_ferr_nxt  = r_ferr_pend | !w_sample;
          w_done      = 1'b1;
          w_state_nxt = RX_IDLE;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // Frame format and divider are frozen for the whole frame at start detection.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_div      <= DIV_W'(1);
      r_two_stop <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
    end else if (w_arm) begin
      r_div      <= w_div_in;
      r_two_stop <= two_stop_bits_i;
      r_par_en   <= parity_bit_i;
      r_par_even <= parity_even_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_busy  <= (w_state_nxt != RX_IDLE);
      if (w_done) begin
        r_data <= r_shift;
        r_perr <= r_perr_pend;
        r_ferr <= w_ferr_nxt;
      end
    end
  end

  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign parity_error_o = r_perr;
  assign frame_error_o  = r_ferr;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural transmitter drives serial_i and
// every valid_o pulse is checked against the queue of expected frames.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  logic        clock_i;
  logic        reset_i;
  logic        two_stop_bits_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic [15:0] clock_divider_i;
  logic        serial_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        parity_error_o;
  logic        frame_error_o;
  logic        busy_o;

  int          errors = 0;
  int          checks = 0;
  int          cur_div = 8;
  rx_exp_t     exp_q[$];
  rx_exp_t     m_exp;

  uart_rx dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .serial_i        (serial_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .busy_o          (busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Every delivered frame must match the oldest outstanding expectation.
  always @(negedge clock_i) begin
    if (valid_o !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data=%02h perr=%b ferr=%b, required no frame",
                 data_o, parity_error_o, frame_error_o);
      end else begin
        m_exp = exp_q.pop_front();
        if ({data_o, parity_error_o, frame_error_o} !== m_exp) begin
          errors++;
          $display("FAIL frame: got data=%02h perr=%b ferr=%b, required data=%02h perr=%b ferr=%b",
                   data_o, parity_error_o, frame_error_o, m_exp.data, m_exp.perr, m_exp.ferr);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic drive(input logic level, input int nclk);
    for (int i = 0; i < nclk; i++) begin
      @(negedge clock_i);
      serial_i = level;
    end
  endtask

  task automatic set_fmt(input int div, input logic par_en, input logic even, input logic two_stop);
    cur_div         = div;
    clock_divider_i = 16'(div);
    parity_bit_i    = par_en;
    parity_even_i   = even;
    two_stop_bits_i = two_stop;
  endtask

  // Drives one frame; glitch is the clock offset from the start edge to invert (-1 for none).
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic s1,
                            input logic s2, input int glitch);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (parity_bit_i) bits.push_back((parity_even_i ? (^d) : ~(^d)) ^ par_flip);
    bits.push_back(s1);
    if (two_stop_bits_i) bits.push_back(s2);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < cur_div; c++) begin
        @(negedge clock_i);
        serial_i = ((k * cur_div + c) == glitch) ? ~bits[k] : bits[k];
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && n < budget) begin
      @(negedge clock_i);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d frames pending busy=%b after %0d clocks, required 0 pending busy=0",
               name, exp_q.size(), busy_o, budget);
      exp_q = {};
    end
  endtask

  task automatic test_reset();
    reset_i  = 1'b0;
    serial_i = 1'b1;
    set_fmt(8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock_i);
    checks++;
    if ({data_o, valid_o, parity_error_o, frame_error_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h valid=%b perr=%b ferr=%b busy=%b, required all 0",
               data_o, valid_o, parity_error_o, frame_error_o, busy_o);
    end
    reset_i = 1'b1;
    drive(1'b1, 20);
  endtask

  task automatic test_back_to_back();
    set_fmt(8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0});
    exp_q.push_back('{data: 8'hA3, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'hA3, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b1, 20);
    wait_drain("back_to_back", 200);
  endtask

  task automatic test_parity();
    set_fmt(16, 1'b1, 1'b1, 1'b0);
    exp_q.push_back('{data: 8'h0F, perr: 1'b1, ferr: 1'b0});
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, -1);
    drive(1'b1, 20);
    wait_drain("parity_even_bad", 300);
    set_fmt(16, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{data: 8'h0F, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b1, 20);
    wait_drain("parity_odd_good", 300);
  endtask

  task automatic test_stop_bits();
    set_fmt(16, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1);
    drive(1'b1, 40);
    wait_drain("stop2_low", 300);
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 40);
    wait_drain("stop1_low", 300);
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b1, 40);
    wait_drain("stop_clean", 300);
  endtask

  task automatic test_reset_midframe();
    set_fmt(8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8);
    drive(1'b1, 8 * 4 + 4);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got busy=%b, required 1", busy_o);
    end
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    checks++;
    if ({data_o, valid_o, parity_error_o, frame_error_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset: got data=%02h valid=%b perr=%b ferr=%b busy=%b, required all 0",
               data_o, valid_o, parity_error_o, frame_error_o, busy_o);
    end
    repeat (3) @(negedge clock_i);
    serial_i = 1'b1;
    reset_i  = 1'b1;
    drive(1'b1, 40);
    exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b1, 20);
    wait_drain("after_reset", 200);
  endtask

  task automatic test_false_start();
    set_fmt(16, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2);
    drive(1'b1, 5);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL false_start_detect: got busy=%b, required 1", busy_o);
    end
    drive(1'b1, 30);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL false_start_abandon: got busy=%b, required 0", busy_o);
    end
    drive(1'b1, 200);
  endtask

  task automatic test_break();
    set_fmt(8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    drive(1'b0, 8 * 14);
    checks++;
    if (busy_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL break_idle: got busy=%b pending=%0d, required busy=0 pending=0",
               busy_o, exp_q.size());
      exp_q = {};
    end
    drive(1'b1, 40);
    wait_drain("break", 100);
  endtask

  // The single-clock glitch lands on the nominal sample of data bit 2 (div/2 clocks into the bit).
  task automatic test_glitch();
    set_fmt(16, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b0});
`else
    exp_q.push_back('{data: 8'h04, perr: 1'b0, ferr: 1'b0});
`endif
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 3 * 16 + 8);
    drive(1'b1, 30);
    wait_drain("glitch", 200);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop_bits();
    test_reset_midframe();
    test_false_start();
    test_break();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
